// File: rtl/rising_edge_detector.sv
// rising_edge_detector: two async push switches -> synchronized, optionally debounced (RISING_EDGE_DEBOUNCE_EN), rising-edge detected, latched LED
module rising_edge_detector #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic PUSH_SW_LEFT,
    input  logic PUSH_SW_RIGHT,
    output logic LED
);
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("rising_edge_detector: parameter out of legal range");
    end
    logic [1:0] sw_in;
    logic [1:0] rise;
    logic       led_q;
    logic       led_d;
    assign sw_in = {PUSH_SW_RIGHT, PUSH_SW_LEFT};
    for (genvar i = 0; i < 2; i++) begin : g_sw
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   level;
        logic                   prev_q;
        // Metastability chain: shift the raw switch in from the LSB end
        always_ff @(posedge clk or posedge rstb) begin
            if (rstb) sync_q <= '0;
            else      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in[i]};
        end
`ifdef RISING_EDGE_DEBOUNCE_EN
        logic [15:0] cnt_q;
        logic [15:0] cnt_d;
        logic        lvl_q;
        logic        lvl_d;
        logic        differs;
        logic        settled;
        assign differs = sync_q[SYNC_STAGES-1] ^ lvl_q;
        assign settled = differs && (cnt_q == 16'(DEBOUNCE_CYCLES - 1));
        // Count consecutive disagreeing cycles; flip the level once enough have passed
        always_comb begin
            cnt_d = !differs ? '0 : settled ? '0 : cnt_q + 16'd1;
            lvl_d = settled ? sync_q[SYNC_STAGES-1] : lvl_q;
        end
        // Debouncer state
        always_ff @(posedge clk or posedge rstb) begin
            if (rstb) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end
        assign level = lvl_q;
`else
        assign level = sync_q[SYNC_STAGES-1];
`endif
        // Previous level; cleared by reset so a switch held through reset yields a fresh edge
        always_ff @(posedge clk or posedge rstb) begin
            if (rstb) prev_q <= 1'b0;
            else      prev_q <= level;
        end
        assign rise[i] = level & ~prev_q;
    end
    // Left sets, right clears, both at once toggles
    always_comb begin
        led_d = (rise[0] && rise[1]) ? ~led_q : rise[0] ? 1'b1 : rise[1] ? 1'b0 : led_q;
    end
    // Registered LED so no input reaches the output combinationally
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) led_q <= 1'b0;
        else      led_q <= led_d;
    end
    assign LED = led_q;
endmodule

// File: tb/tb_rising_edge_detector.sv
// tb_rising_edge_detector: directed self-checking bench for rising_edge_detector
module tb_rising_edge_detector;
    logic clk = 1'b0;
    logic rstb = 1'b1;
    logic left = 1'b0;
    logic right = 1'b0;
    logic led;
    int tests = 0;
    int fails = 0;
`ifdef RISING_EDGE_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    always #5 clk = ~clk;

    rising_edge_detector #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rstb(rstb),
        .PUSH_SW_LEFT(left),
        .PUSH_SW_RIGHT(right),
        .LED(led)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            left = i[0];
            right = i[1];
            step();
            tests++;
            if (led !== 1'b0) begin fails++; $display("FAIL reset_hold cyc=%0d led=%b exp=0", i, led); end
        end
        @(negedge clk);
        left = 1'b0;
        right = 1'b0;
        rstb = 1'b0;
        repeat (3) step();
        @(negedge clk);
        left = 1'b1;
        repeat (LAT + 1) step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL reset_pre_on led=%b exp=1", led); end
        #3 rstb = 1'b1;
        #1;
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL reset_async led=%b exp=0", led); end
        @(negedge clk);
        left = 1'b0;
        rstb = 1'b0;
        repeat (LAT + 3) step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL reset_after led=%b exp=0", led); end
    endtask

    task automatic test_left();
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            left = 1'b1;
            step();
            tests++;
            if (led !== (p == 1)) begin fails++; $display("FAIL left_e0 p=%0d led=%b exp=%b", p, led, p == 1); end
            @(negedge clk);
            left = 1'b0;
            step();
            tests++;
            if (led !== (p == 1)) begin fails++; $display("FAIL left_e1 p=%0d led=%b exp=%b", p, led, p == 1); end
            step();
            tests++;
            if (led !== 1'b1) begin fails++; $display("FAIL left_e2 p=%0d led=%b exp=1", p, led); end
            repeat (4) step();
            tests++;
            if (led !== 1'b1) begin fails++; $display("FAIL left_stay p=%0d led=%b exp=1", p, led); end
        end
    endtask

    task automatic test_right();
        @(negedge clk);
        right = 1'b1;
        step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL right_e0 led=%b exp=1", led); end
        @(negedge clk);
        right = 1'b0;
        step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL right_e1 led=%b exp=1", led); end
        step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL right_e2 led=%b exp=0", led); end
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k % 2 == 0) left = 1'b1;
            else            right = 1'b1;
            step();
            tests++;
            if (led !== (k % 2 == 1)) begin fails++; $display("FAIL alt_a k=%0d led=%b exp=%b", k, led, k % 2 == 1); end
            @(negedge clk);
            left = 1'b0;
            right = 1'b0;
            step();
            tests++;
            if (led !== (k % 2 == 1)) begin fails++; $display("FAIL alt_b k=%0d led=%b exp=%b", k, led, k % 2 == 1); end
        end
        step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL alt_end led=%b exp=0", led); end
    endtask

    task automatic test_simultaneous();
        for (int p = 0; p < 2; p++) begin
            repeat (3) step();
            @(negedge clk);
            left = 1'b1;
            right = 1'b1;
            @(negedge clk);
            left = 1'b0;
            right = 1'b0;
            step();
            tests++;
            if (led !== (p == 1)) begin fails++; $display("FAIL simul_early p=%0d led=%b exp=%b", p, led, p == 1); end
            step();
            tests++;
            if (led !== (p == 0)) begin fails++; $display("FAIL simul_toggle p=%0d led=%b exp=%b", p, led, p == 0); end
        end
    endtask

    task automatic test_held();
        int high_cycles;
        repeat (3) step();
        @(negedge clk);
        left = 1'b1;
        repeat (3) step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL held_set led=%b exp=1", led); end
        repeat (15) step();
        @(negedge clk);
        right = 1'b1;
        step();
        @(negedge clk);
        right = 1'b0;
        step();
        step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL held_right_clear led=%b exp=0", led); end
        high_cycles = 0;
        repeat (78) begin
            step();
            if (led) high_cycles++;
        end
        tests++;
        if (high_cycles !== 0) begin fails++; $display("FAIL held_no_reset high_cycles=%0d exp=0", high_cycles); end
        @(negedge clk);
        left = 1'b0;
        repeat (5) step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL held_release led=%b exp=0", led); end
    endtask

    task automatic test_reset_midpress();
        @(negedge clk);
        left = 1'b1;
        repeat (3) step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL midpress_on led=%b exp=1", led); end
        #3 rstb = 1'b1;
        #1;
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL midpress_rst led=%b exp=0", led); end
        @(negedge clk);
        rstb = 1'b0;
        step();
        step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL midpress_e1 led=%b exp=0", led); end
        step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL midpress_edge led=%b exp=1", led); end
        @(negedge clk);
        left = 1'b0;
    endtask

    task automatic test_debounce();
        @(negedge clk);
        left = 1'b1;
        repeat (3) @(negedge clk);
        left = 1'b0;
        repeat (15) step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL deb_glitch led=%b exp=0", led); end
        @(negedge clk);
        left = 1'b1;
        step();
        repeat (5) step();
        tests++;
        if (led !== 1'b0) begin fails++; $display("FAIL deb_early led=%b exp=0", led); end
        @(negedge clk);
        left = 1'b0;
        step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL deb_set led=%b exp=1", led); end
        repeat (10) step();
        tests++;
        if (led !== 1'b1) begin fails++; $display("FAIL deb_hold led=%b exp=1", led); end
    endtask

    initial begin
        test_reset();
`ifdef RISING_EDGE_DEBOUNCE_EN
        test_debounce();
`else
        test_left();
        test_right();
        test_simultaneous();
        test_held();
        test_reset_midpress();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rising_edge_detector.md
# rising_edge_detector

Push-button front end that turns two asynchronous switch inputs into a single latched LED state. Each switch is synchronized into the `clk` domain, optionally debounced, and rising-edge detected. A LEFT press turns the LED on; a RIGHT press turns it off. The block sits between board-level push switches and the LED driver.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per switch input; legal range 2–4.
- `DEBOUNCE_CYCLES`, default 4: number of stable cycles needed before a debounced level changes; used only when `RISING_EDGE_DEBOUNCE_EN` is defined; legal range 1–65535.
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `rstb`, input, 1: reset, **asynchronous, active-high**; `rstb`=1 clears all state immediately.
- `PUSH_SW_LEFT`, input, 1: asynchronous switch input, active-high; pressing it sets the LED.
- `PUSH_SW_RIGHT`, input, 1: asynchronous switch input, active-high; pressing it clears the LED.
- `LED`, output, 1: registered LED state; 1 = on.

## Operation
- **Per-switch path:** `SYNC_STAGES`-deep flop chain → optional debouncer → previous-level register.
- **Edge detection:**
  - `rise_L = sync_L & ~prev_L`; `rise_R` is formed the same way.
  - Each is a one-cycle pulse.
  - Only a 0→1 transition counts. A held level produces exactly one pulse. A falling edge produces nothing.
- **LED update, registered:**
  - `rise_L` only → `LED` = 1.
  - `rise_R` only → `LED` = 0.
  - `rise_L` and `rise_R` in the same cycle → `LED` toggles.
  - Neither → `LED` holds.
- Repeated LEFT presses while `LED` = 1 leave it at 1. Repeated RIGHT presses while `LED` = 0 leave it at 0.
- **Reset:** `rstb` = 1 asynchronously clears every synchronizer flop, every prev register, every debouncer counter and level, and `LED`.
  - Reset state is `LED` = 0.
  - Reset mid-press: a switch still held when `rstb` falls is seen as a new 0→1 edge, because prev = 0 after reset.
- No combinational path from any input to `LED`.

## Timing
- Without debounce, a switch high at rising edge E0 sets `prev` and `LED` at edge E0+`SYNC_STAGES`. With the default, `LED` changes at the 3rd edge counting E0 as the 1st.
- With debounce, add `DEBOUNCE_CYCLES` cycles of latency.
- Minimum detectable pulse: one full `clk` period high, so that it is sampled by at least one edge. Shorter pulses are not guaranteed to be caught.
- Minimum low time between presses: one period without debounce; `DEBOUNCE_CYCLES`+1 periods with debounce.
- LEFT and RIGHT edges that reach the detector in different cycles are processed independently, in arrival order.

## Configuration
- Macro: `RISING_EDGE_DEBOUNCE_EN`.
- **Defined:** each synchronized input feeds a counter.
  - While the input differs from the current debounced level, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Any cycle where the input equals the debounced level clears the counter.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- **Undefined:** the debouncer is removed entirely. The synchronizer output drives the edge detector directly, and `DEBOUNCE_CYCLES` is unused.

## Test plan
Bench: 10 ns clock, macro undefined unless stated.
- **Reset:** hold `rstb`=1 with both switches toggling → `LED` = 0 throughout. Assert `rstb` mid-operation while `LED`=1 → `LED` = 0 within the same time step.
- **Single LEFT press:** `PUSH_SW_LEFT`=1 for 10 ns from `LED`=0 → `LED` = 1 at the 3rd rising edge after the press and stays 1 after release. A second 10 ns LEFT pulse → `LED` stays 1.
- **RIGHT press:** RIGHT pulse for 10 ns from `LED`=1 → `LED` = 0 two edges after sampling. Alternating L, R, L, R pulses spaced 20 ns → `LED` goes 1, 0, 1, 0.
- **Simultaneous press:** both switches rise in the same cycle from `LED`=0 → `LED` = 1. Repeat from `LED`=1 → `LED` = 0.
- **Held switch:** LEFT held high for 100 cycles → exactly one edge; `LED` = 1, and a RIGHT pulse during the hold clears it to 0 with no re-set.
- **Debounce, macro defined, `DEBOUNCE_CYCLES`=4:**
  - A 3-cycle LEFT pulse → `LED` unchanged.
  - A 6-cycle LEFT pulse → `LED` = 1, 2+4 cycles after sampling.
